// File: rtl/mips_pipeline_mem_pkg.sv
// Shared encodings, state type and bundle layouts for the MIPS MEM stage.
package mips_pipeline_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUS   = 2'b10;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic        valid;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_signed;
        logic        reg_write;
        logic [4:0]  dest_reg;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic        misaligned;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  dest_reg;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [1:0]  fault;
    } mem_wb_t;

    function automatic int timeout_cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

    // Size code 11 behaves as a word everywhere.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~addr_lo[0];
            SIZE_WORD: return addr_lo == 2'b00;
            default:   return addr_lo == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mips_pipeline_mem_lane.sv
// Little-endian byte-lane logic: store enables/replication and load extract/extend.
module mips_pipeline_mem_lane
    import mips_pipeline_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_signed,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = shifted;
        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << lane;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                be        = 4'b0011 << lane;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_pipeline_mem_stage.sv
// MEM stage: EX/MEM register, req/ack data-memory access with timeout, MEM/WB register.
module mips_pipeline_mem_stage
    import mips_pipeline_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [1:0]  in_mem_size,
    input  logic        in_mem_signed,
    input  logic        in_reg_write,
    input  logic [4:0]  in_dest_reg,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic        out_reg_write,
    output logic        out_mem_to_reg,
    output logic [4:0]  out_dest_reg,
    output logic [31:0] out_alu_result,
    output logic [31:0] out_load_data,
    output logic [1:0]  out_fault
);

    localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

    state_t           state;
    ex_mem_t          cur;
    ex_mem_t          cur_next;
    mem_wb_t          wb;
    mem_wb_t          wb_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             access;
    logic             timeout_now;
    logic             in_is_mem;
    logic             in_aligned;
    logic [3:0]       lane_be;
    logic [31:0]      lane_load;

    assign access      = (state == ACCESS);
    assign timeout_now = access & ~dmem_ack & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign stall_out   = access & ~dmem_ack & ~timeout_now;

    assign in_is_mem  = in_valid & (in_mem_read | in_mem_write);
    assign in_aligned = is_aligned(in_mem_size, in_alu_result[1:0]);

    always_comb begin
        cur_next            = '0;
        cur_next.valid      = in_valid;
        cur_next.mem_read   = in_mem_read;
        cur_next.mem_write  = in_mem_write;
        cur_next.mem_size   = in_mem_size;
        cur_next.mem_signed = in_mem_signed;
        cur_next.reg_write  = in_reg_write;
        cur_next.dest_reg   = in_dest_reg;
        cur_next.alu_result = in_alu_result;
        cur_next.store_data = in_store_data;
        cur_next.misaligned = in_is_mem & ~in_aligned;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cur      <= '0;
            wait_cnt <= '0;
        end else if (!stall_out) begin
            cur      <= cur_next;
            state    <= (in_is_mem && in_aligned) ? ACCESS : IDLE;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    mips_pipeline_mem_lane u_lane (
        .size       (cur.mem_size),
        .lane       (cur.alu_result[1:0]),
        .is_signed  (cur.mem_signed),
        .store_data (cur.store_data),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (dmem_wdata),
        .load_data  (lane_load)
    );

    assign dmem_req  = access;
    assign dmem_we   = access & cur.mem_write;
    assign dmem_addr = cur.alu_result[31:2];
    assign dmem_be   = access ? lane_be : 4'b0000;

    // Faulted ops become bubbles carrying only the fault code.
    always_comb begin
        wb_next       = '0;
        wb_next.fault = FAULT_NONE;
        if (timeout_now) begin
            wb_next.fault = FAULT_BUS;
        end else if (cur.valid && cur.misaligned) begin
            wb_next.fault = FAULT_ALIGN;
        end else if (cur.valid) begin
            wb_next.valid      = 1'b1;
            wb_next.reg_write  = cur.reg_write & ~cur.mem_write;
            wb_next.mem_to_reg = cur.mem_read & ~cur.mem_write;
            wb_next.dest_reg   = cur.dest_reg;
            wb_next.alu_result = cur.alu_result;
            if (cur.mem_read && !cur.mem_write) begin
                wb_next.load_data = lane_load;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb <= '0;
        end else if (!stall_out) begin
            wb <= wb_next;
        end
    end

    assign out_valid      = wb.valid;
    assign out_reg_write  = wb.reg_write;
    assign out_mem_to_reg = wb.mem_to_reg;
    assign out_dest_reg   = wb.dest_reg;
    assign out_alu_result = wb.alu_result;
    assign out_load_data  = wb.load_data;
    assign out_fault      = wb.fault;

endmodule

// File: tb/tb_mips_pipeline_mem_stage.sv
// Self-checking bench for mips_pipeline_mem_stage: directed scenarios plus randomized ops vs a behavioural model.
module tb_mips_pipeline_mem_stage;

    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic        valid;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic        rw;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] sdata;
    } op_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] load;
        logic [1:0]  fault;
    } wb_t;

    localparam op_t BUBBLE = '0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_mem_read, in_mem_write, in_mem_signed, in_reg_write;
    logic [1:0]  in_mem_size;
    logic [4:0]  in_dest_reg;
    logic [31:0] in_alu_result, in_store_data;
    logic        stall_out, dmem_req, dmem_we, dmem_ack;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        out_valid, out_reg_write, out_mem_to_reg;
    logic [4:0]  out_dest_reg;
    logic [31:0] out_alu_result, out_load_data;
    logic [1:0]  out_fault;
    logic [142:0] all_outs;

    int n_pass  = 0;
    int n_total = 0;

    mips_pipeline_mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_mem_size    (in_mem_size),
        .in_mem_signed  (in_mem_signed),
        .in_reg_write   (in_reg_write),
        .in_dest_reg    (in_dest_reg),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .stall_out      (stall_out),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .out_valid      (out_valid),
        .out_reg_write  (out_reg_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_dest_reg   (out_dest_reg),
        .out_alu_result (out_alu_result),
        .out_load_data  (out_load_data),
        .out_fault      (out_fault)
    );

    assign all_outs = {stall_out, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                       out_valid, out_reg_write, out_mem_to_reg, out_dest_reg,
                       out_alu_result, out_load_data, out_fault};

    initial forever #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    function automatic op_t mk_op(input int kind, input logic [1:0] size, input logic sgn,
                                  input logic [4:0] dest, input logic [31:0] addr,
                                  input logic [31:0] sdata);
        op_t o;
        o       = '0;
        o.valid = (kind != 3);
        o.rd    = (kind == 1);
        o.wr    = (kind == 2);
        o.size  = size;
        o.sgn   = sgn;
        o.rw    = (kind != 3);
        o.dest  = dest;
        o.alu   = addr;
        o.sdata = sdata;
        return o;
    endfunction

    function automatic bit model_aligned(input op_t o);
        int unsigned a;
        a = o.alu;
        if (o.size == 2'd0) return 1'b1;
        if (o.size == 2'd1) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic logic [3:0] model_be(input op_t o);
        int unsigned lane;
        lane = o.alu % 4;
        if (o.size == 2'd0) return 4'(1 << lane);
        if (o.size == 2'd1) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input op_t o);
        int unsigned d;
        d = o.sdata;
        if (o.size == 2'd0) return (d % 256) * 32'h0101_0101;
        if (o.size == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input op_t o, input logic [31:0] rdata);
        int unsigned v;
        v = rdata >> (8 * (o.alu % 4));
        if (o.size == 2'd0) begin
            v = v % 256;
            if (o.sgn && v >= 128) v = v - 256;
        end else if (o.size == 2'd1) begin
            v = v % 65536;
            if (o.sgn && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic wb_t model_wb(input op_t o, input logic [31:0] rdata);
        wb_t w;
        bit  is_load;
        is_load      = o.rd && !o.wr;
        w            = '0;
        w.valid      = 1'b1;
        w.reg_write  = o.rw && !o.wr;
        w.mem_to_reg = is_load;
        w.dest       = o.dest;
        w.alu        = o.alu;
        w.load       = is_load ? model_load(o, rdata) : 32'h0;
        return w;
    endfunction

    task automatic drive(input op_t o);
        in_valid      = o.valid;
        in_mem_read   = o.rd;
        in_mem_write  = o.wr;
        in_mem_size   = o.size;
        in_mem_signed = o.sgn;
        in_reg_write  = o.rw;
        in_dest_reg   = o.dest;
        in_alu_result = o.alu;
        in_store_data = o.sdata;
    endtask

    // Issues one op with an idle upstream afterwards; ends at the negedge after write-back.
    task automatic do_txn(input op_t op, input int waits, input logic [31:0] rdata, input string tag);
        bit   mem_op, go, exp_stall;
        wb_t  exp_wb, act_wb;
        mem_op = op.valid && (op.rd || op.wr);
        go     = mem_op && model_aligned(op);
        drive(op);
        dmem_ack = 1'b0;
        @(negedge clock);
        drive(BUBBLE);
        if (go) begin
            for (int w = 0; w <= waits; w++) begin
                dmem_ack   = (w == waits);
                dmem_rdata = (w == waits) ? rdata : $urandom;
                exp_stall  = (w != waits);
                #1;
                n_total++;
                if ({dmem_req, dmem_we, dmem_addr, dmem_be, stall_out} !==
                    {1'b1, op.wr, op.alu[31:2], model_be(op), exp_stall})
                    $display("FAIL %s access cyc %0d: req/we/addr/be/stall got %b/%b/%h/%b/%b exp 1/%b/%h/%b/%b",
                             tag, w, dmem_req, dmem_we, dmem_addr, dmem_be, stall_out,
                             op.wr, op.alu[31:2], model_be(op), exp_stall);
                else n_pass++;
                if (op.wr) begin
                    n_total++;
                    if (dmem_wdata !== model_wdata(op))
                        $display("FAIL %s wdata got %h exp %h", tag, dmem_wdata, model_wdata(op));
                    else n_pass++;
                end
                @(negedge clock);
            end
            dmem_ack = 1'b0;
        end else begin
            #1;
            n_total++;
            if (dmem_req !== 1'b0 || stall_out !== 1'b0)
                $display("FAIL %s no_access: req/stall got %b/%b exp 0/0", tag, dmem_req, stall_out);
            else n_pass++;
            @(negedge clock);
        end
        n_total++;
        if (!op.valid) begin
            if (out_valid !== 1'b0) $display("FAIL %s bubble out_valid got %b exp 0", tag, out_valid);
            else n_pass++;
        end else if (!go && mem_op) begin
            if ({out_valid, out_reg_write, out_fault} !== 4'b0001)
                $display("FAIL %s align_fault valid/rw/fault got %b/%b/%b exp 0/0/01",
                         tag, out_valid, out_reg_write, out_fault);
            else n_pass++;
        end else begin
            exp_wb = model_wb(op, rdata);
            act_wb = {out_valid, out_reg_write, out_mem_to_reg, out_dest_reg,
                      out_alu_result, (op.wr ? 32'h0 : out_load_data), out_fault};
            if (act_wb !== exp_wb) $display("FAIL %s wb got %h exp %h", tag, act_wb, exp_wb);
            else n_pass++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(BUBBLE);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        #1;
        n_total++;
        if (all_outs !== '0) $display("FAIL reset_state outputs got %h exp 0", all_outs);
        else n_pass++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_alu_op();
        do_txn(mk_op(0, 2'b10, 1'b0, 5'd5, 32'h1234, 32'h0), 0, 32'h0, "alu_op");
        n_total++;
        if (dmem_req !== 1'b0) $display("FAIL alu_no_req got %b exp 0", dmem_req);
        else n_pass++;
    endtask

    task automatic test_signed_byte_load();
        do_txn(mk_op(1, 2'b00, 1'b1, 5'd9, 32'h103, 32'h0), 0, 32'h80FF_0000, "lb_signed");
        n_total++;
        if (out_load_data !== 32'hFFFF_FF80) $display("FAIL lb_signed_data got %h exp ffffff80", out_load_data);
        else n_pass++;
    endtask

    task automatic test_half_store_waits();
        op_t st, nxt;
        int  stalls;
        stalls = 0;
        st  = mk_op(2, 2'b01, 1'b0, 5'd3, 32'h202, 32'h0000_ABCD);
        nxt = mk_op(0, 2'b10, 1'b0, 5'd7, 32'h55AA, 32'h0);
        drive(st);
        dmem_ack = 1'b0;
        @(negedge clock);
        drive(nxt);
        for (int w = 0; w < 4; w++) begin
            dmem_ack = (w == 3);
            #1;
            if (stall_out) stalls++;
            n_total++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
                {1'b1, 1'b1, 30'h80, 4'b1100, 32'hABCD_ABCD})
                $display("FAIL sh_stable cyc %0d got %b/%b/%h/%b/%h exp 1/1/80/1100/abcdabcd",
                         w, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
            else n_pass++;
            @(negedge clock);
        end
        dmem_ack = 1'b0;
        drive(BUBBLE);
        n_total++;
        if (stalls != 3) $display("FAIL sh_stall_cycles got %0d exp 3", stalls);
        else n_pass++;
        n_total++;
        if ({out_valid, out_reg_write, out_mem_to_reg, out_fault} !== 5'b10000)
            $display("FAIL sh_wb valid/rw/m2r/fault got %b/%b/%b/%b exp 1/0/0/00",
                     out_valid, out_reg_write, out_mem_to_reg, out_fault);
        else n_pass++;
        #1;
        n_total++;
        if (dmem_req !== 1'b0) $display("FAIL sh_next_no_req got %b exp 0", dmem_req);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if ({out_valid, out_dest_reg, out_alu_result} !== {1'b1, 5'd7, 32'h55AA})
            $display("FAIL sh_upstream_wb got %b/%0d/%h exp 1/7/55aa", out_valid, out_dest_reg, out_alu_result);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        do_txn(mk_op(1, 2'b10, 1'b0, 5'd4, 32'h6, 32'h0), 0, 32'h0, "lw_misaligned");
        @(negedge clock);
        n_total++;
        if ({out_valid, out_fault} !== 3'b000)
            $display("FAIL misaligned_one_cycle valid/fault got %b/%b exp 0/00", out_valid, out_fault);
        else n_pass++;
    endtask

    task automatic test_timeout();
        op_t ld;
        ld = mk_op(1, 2'b10, 1'b0, 5'd8, 32'h100, 32'h0);
        drive(ld);
        dmem_ack = 1'b0;
        @(negedge clock);
        drive(BUBBLE);
        for (int c = 0; c < TIMEOUT; c++) begin
            #1;
            n_total++;
            if ({dmem_req, stall_out} !== {1'b1, (c < TIMEOUT - 1) ? 1'b1 : 1'b0})
                $display("FAIL timeout_cyc %0d req/stall got %b/%b", c, dmem_req, stall_out);
            else n_pass++;
            @(negedge clock);
        end
        n_total++;
        if ({dmem_req, stall_out, out_valid, out_reg_write, out_fault} !== 6'b000010)
            $display("FAIL timeout_fault req/stall/valid/rw/fault got %b/%b/%b/%b/%b exp 0/0/0/0/10",
                     dmem_req, stall_out, out_valid, out_reg_write, out_fault);
        else n_pass++;
        do_txn(ld, TIMEOUT - 1, 32'h1357_9BDF, "ack_on_last_cycle");
    endtask

    task automatic test_reset_mid_access();
        drive(mk_op(1, 2'b10, 1'b0, 5'd6, 32'h300, 32'h0));
        dmem_ack = 1'b0;
        @(negedge clock);
        drive(BUBBLE);
        @(negedge clock);
        #1;
        n_total++;
        if (dmem_req !== 1'b1) $display("FAIL rst_mid_pre req got %b exp 1", dmem_req);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (all_outs !== '0) $display("FAIL rst_mid_outputs got %h exp 0", all_outs);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        do_txn(mk_op(0, 2'b10, 1'b0, 5'd12, 32'hCAFE, 32'h0), 0, 32'h0, "alu_after_reset");
    endtask

    task automatic test_back_to_back();
        op_t a, b;
        wb_t exp_wb, act_wb;
        logic [31:0] ra, rb;
        a  = mk_op(1, 2'b10, 1'b0, 5'd10, 32'h40, 32'h0);
        b  = mk_op(1, 2'b00, 1'b0, 5'd11, 32'h41, 32'h0);
        ra = $urandom;
        rb = $urandom;
        drive(a);
        @(negedge clock);
        drive(b);
        dmem_ack   = 1'b1;
        dmem_rdata = ra;
        @(negedge clock);
        drive(BUBBLE);
        exp_wb = model_wb(a, ra);
        act_wb = {out_valid, out_reg_write, out_mem_to_reg, out_dest_reg, out_alu_result, out_load_data, out_fault};
        n_total++;
        if (act_wb !== exp_wb) $display("FAIL b2b_first_wb got %h exp %h", act_wb, exp_wb);
        else n_pass++;
        dmem_rdata = rb;
        #1;
        n_total++;
        if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, b.alu[31:2], model_be(b)})
            $display("FAIL b2b_second_access req/addr/be got %b/%h/%b exp 1/%h/%b",
                     dmem_req, dmem_addr, dmem_be, b.alu[31:2], model_be(b));
        else n_pass++;
        @(negedge clock);
        dmem_ack = 1'b0;
        exp_wb = model_wb(b, rb);
        act_wb = {out_valid, out_reg_write, out_mem_to_reg, out_dest_reg, out_alu_result, out_load_data, out_fault};
        n_total++;
        if (act_wb !== exp_wb) $display("FAIL b2b_second_wb got %h exp %h", act_wb, exp_wb);
        else n_pass++;
    endtask

    task automatic test_random();
        op_t         o;
        int          sel, kind;
        logic [1:0]  size;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            sel  = $urandom_range(0, 9);
            kind = (sel < 3) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3;
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                else if (size != 2'd0) addr[1:0] = 2'b00;
            end
            o = mk_op(kind, size, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), addr, $urandom);
            do_txn(o, $urandom_range(0, TIMEOUT - 1), $urandom, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_signed_byte_load();
        test_half_store_waits();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
